// File: rtl/fifo36e2.sv
// 512 x 72 single-clock first-word-fall-through FIFO with occupancy, threshold flags and reset-busy sequencing.
// Optional macro FIFO36E2_PARITY_EN: store DINP alongside DIN and return it on DOUTP.
module fifo36e2 #(
  parameter logic [12:0] PROG_EMPTY_THRESH = 13'd128,
  parameter logic [12:0] PROG_FULL_THRESH  = 13'd256,
  parameter logic [71:0] SRVAL             = 72'd0
) (
  input  logic        WRCLK,
  input  logic        RST,
  input  logic        SLEEP,
  input  logic        WREN,
  input  logic [63:0] DIN,
  input  logic [7:0]  DINP,
  input  logic        RDEN,
  output logic [63:0] DOUT,
  output logic [7:0]  DOUTP,
  output logic        FULL,
  output logic        PROGFULL,
  output logic        EMPTY,
  output logic        PROGEMPTY,
  output logic [13:0] WRCOUNT,
  output logic [13:0] RDCOUNT,
  output logic        WRERR,
  output logic        RDERR,
  output logic        WRRSTBUSY,
  output logic        RDRSTBUSY
);

  localparam int unsigned DEPTH = 512;
  localparam int unsigned AW    = 9;
  localparam int unsigned CW    = 10;
`ifdef FIFO36E2_PARITY_EN
  localparam int unsigned MW    = 72;
`else
  localparam int unsigned MW    = 64;
`endif

  typedef enum logic [1:0] {ST_RESET, ST_BUSY, ST_IDLE} rst_state_e;

  rst_state_e     state;
  logic [1:0]     busy_cnt;
  logic           busy_q;

  logic [MW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wrptr, rdptr;
  logic [CW-1:0]  count;
  logic [MW-1:0]  head_q;
  logic           full_q, empty_q, progfull_q, progempty_q;
  logic           wrerr_q, rderr_q;

  logic           active, wr_req, rd_req, wr_ok, rd_ok;
  logic [AW-1:0]  wrptr_nxt, rdptr_nxt;
  logic [CW-1:0]  count_nxt;
  logic [MW-1:0]  wdata, head_nxt;

`ifdef FIFO36E2_PARITY_EN
  assign wdata = {DINP, DIN};
`else
  logic unused_dinp;
  assign unused_dinp = ^DINP;
  assign wdata = DIN;
`endif

  // Reset sequencer: RESET while RST is high, then four edges of busy before IDLE.
  always_ff @(posedge WRCLK or posedge RST) begin
    if (RST) begin
      state    <= ST_RESET;
      busy_cnt <= 2'd0;
      busy_q   <= 1'b1;
    end else begin
      case (state)
        ST_RESET: begin
          state    <= ST_BUSY;
          busy_cnt <= 2'd2;
        end
        ST_BUSY: begin
          if (busy_cnt == 2'd0) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            busy_cnt <= busy_cnt - 2'd1;
          end
        end
        ST_IDLE: ;
        default: begin
          state  <= ST_RESET;
          busy_q <= 1'b1;
        end
      endcase
    end
  end

  // Request qualification and next-state datapath; head_nxt bypasses a word written into the new head slot.
  always_comb begin
    active    = ~busy_q & ~SLEEP;
    wr_req    = WREN & active;
    rd_req    = RDEN & active;
    wr_ok     = wr_req & ~full_q;
    rd_ok     = rd_req & ~empty_q;
    wrptr_nxt = wrptr + AW'(wr_ok);
    rdptr_nxt = rdptr + AW'(rd_ok);
    count_nxt = count + CW'(wr_ok) - CW'(rd_ok);
    head_nxt  = mem[rdptr_nxt];
    if (count_nxt == CW'(0))
      head_nxt = SRVAL[MW-1:0];
    else if (wr_ok && (wrptr == rdptr_nxt))
      head_nxt = wdata;
  end

  always_ff @(posedge WRCLK) begin
    if (wr_ok)
      mem[wrptr] <= wdata;
  end

  always_ff @(posedge WRCLK or posedge RST) begin
    if (RST) begin
      wrptr       <= '0;
      rdptr       <= '0;
      count       <= '0;
      head_q      <= SRVAL[MW-1:0];
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      progfull_q  <= 1'b0;
      progempty_q <= 1'b1;
      wrerr_q     <= 1'b0;
      rderr_q     <= 1'b0;
    end else begin
      wrptr       <= wrptr_nxt;
      rdptr       <= rdptr_nxt;
      count       <= count_nxt;
      head_q      <= head_nxt;
      full_q      <= (count_nxt == CW'(DEPTH));
      empty_q     <= (count_nxt == CW'(0));
      progfull_q  <= (13'(count_nxt) >= PROG_FULL_THRESH);
      progempty_q <= (13'(count_nxt) <= PROG_EMPTY_THRESH);
      wrerr_q     <= wr_req & full_q;
      rderr_q     <= rd_req & empty_q;
    end
  end

  assign DOUT      = head_q[63:0];
`ifdef FIFO36E2_PARITY_EN
  assign DOUTP     = head_q[71:64];
`else
  assign DOUTP     = SRVAL[71:64];
`endif
  assign FULL      = full_q;
  assign EMPTY     = empty_q;
  assign PROGFULL  = progfull_q;
  assign PROGEMPTY = progempty_q;
  assign WRCOUNT   = {4'd0, count};
  assign RDCOUNT   = {4'd0, count};
  assign WRERR     = wrerr_q;
  assign RDERR     = rderr_q;
  assign WRRSTBUSY = busy_q;
  assign RDRSTBUSY = busy_q;

endmodule

// File: tb/tb_fifo36e2.sv
// Self-checking bench for fifo36e2: vector table plus a queue-based scoreboard of FIFO contents and flags.
module tb_fifo36e2;

  logic        WRCLK = 1'b0;
  logic        RST   = 1'b0;
  logic        SLEEP = 1'b0;
  logic        WREN  = 1'b0;
  logic        RDEN  = 1'b0;
  logic [63:0] DIN   = '0;
  logic [7:0]  DINP  = '0;
  logic [63:0] DOUT;
  logic [7:0]  DOUTP;
  logic        FULL, PROGFULL, EMPTY, PROGEMPTY;
  logic [13:0] WRCOUNT, RDCOUNT;
  logic        WRERR, RDERR, WRRSTBUSY, RDRSTBUSY;

  fifo36e2 dut (
    .WRCLK(WRCLK), .RST(RST), .SLEEP(SLEEP), .WREN(WREN), .DIN(DIN), .DINP(DINP),
    .RDEN(RDEN), .DOUT(DOUT), .DOUTP(DOUTP), .FULL(FULL), .PROGFULL(PROGFULL),
    .EMPTY(EMPTY), .PROGEMPTY(PROGEMPTY), .WRCOUNT(WRCOUNT), .RDCOUNT(RDCOUNT),
    .WRERR(WRERR), .RDERR(RDERR), .WRRSTBUSY(WRRSTBUSY), .RDRSTBUSY(RDRSTBUSY)
  );

  always #5 WRCLK = ~WRCLK;

  localparam logic [63:0] BASE  = 64'hFEDCBA98_76543210;
  localparam logic [63:0] TBASE = 64'hA5A5_0000_0000_0000;

  int          errors = 0;
  int          checks = 0;
  logic [71:0] m_q[$];
  int          m_edges = 0;
  logic        m_wrerr = 1'b0;
  logic        m_rderr = 1'b0;

  typedef struct {
    logic wr;
    logic rd;
    logic slp;
    int   cnt;
    logic wrerr;
    logic rderr;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int          c;
    logic [71:0] head;
    logic        busy;
    c    = m_q.size();
    head = (c != 0) ? m_q[0] : 72'd0;
    busy = (m_edges < 4);
    chk("wrcount", 72'(WRCOUNT), 72'(c));
    chk("rdcount", 72'(RDCOUNT), 72'(c));
    chk("empty", 72'(EMPTY), 72'(c == 0));
    chk("full", 72'(FULL), 72'(c == 512));
    chk("progempty", 72'(PROGEMPTY), 72'(c <= 128));
    chk("progfull", 72'(PROGFULL), 72'(c >= 256));
    chk("wrrstbusy", 72'(WRRSTBUSY), 72'(busy));
    chk("rdrstbusy", 72'(RDRSTBUSY), 72'(busy));
    chk("wrerr", 72'(WRERR), 72'(m_wrerr));
    chk("rderr", 72'(RDERR), 72'(m_rderr));
    chk("dout", 72'(DOUT), 72'(head[63:0]));
`ifdef FIFO36E2_PARITY_EN
    chk("doutp", 72'(DOUTP), 72'(head[71:64]));
`else
    chk("doutp", 72'(DOUTP), 72'd0);
`endif
  endtask

  // One clock: drive, predict from pre-edge model state, advance model, compare.
  task automatic cycle(input logic wr, input logic rd, input logic slp,
                       input logic [63:0] d, input logic [7:0] dp);
    logic act, wr_ok, rd_ok;
    WREN  = wr;
    RDEN  = rd;
    SLEEP = slp;
    DIN   = d;
    DINP  = dp;
    act     = (m_edges >= 4) && !slp && !RST;
    wr_ok   = wr && act && (m_q.size() < 512);
    rd_ok   = rd && act && (m_q.size() > 0);
    m_wrerr = wr && act && (m_q.size() == 512);
    m_rderr = rd && act && (m_q.size() == 0);
    @(posedge WRCLK);
    #1;
    if (rd_ok) void'(m_q.pop_front());
    if (wr_ok) m_q.push_back({dp, d});
    if (RST) m_edges = 0;
    else if (m_edges < 4) m_edges++;
    WREN  = 1'b0;
    RDEN  = 1'b0;
    SLEEP = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    m_q.delete();
    m_edges = 0;
    m_wrerr = 1'b0;
    m_rderr = 1'b0;
    check_all();
    repeat (10) cycle(1'b0, 1'b0, 1'b0, 64'd0, 8'd0);
    RST = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 64'd0, 8'd0);
      chk("busy_after_release", 72'(WRRSTBUSY), 72'(i < 4));
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};

    #2;
    do_reset();
    chk("reset_dout", 72'(DOUT), 72'd0);

    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].wr, vecs[i].rd, vecs[i].slp, TBASE + 64'(i), 8'(i));
      chk("tbl_count", 72'(WRCOUNT), 72'(vecs[i].cnt));
      chk("tbl_wrerr", 72'(WRERR), 72'(vecs[i].wrerr));
      chk("tbl_rderr", 72'(RDERR), 72'(vecs[i].rderr));
    end

    // Fill to full, watching the threshold crossings.
    for (int i = 0; i < 512; i++) begin
      cycle(1'b1, 1'b0, 1'b0, BASE + 64'(i), 8'(i));
      if (i == 0)   chk("fill_first_dout", 72'(DOUT), 72'(BASE));
      if (i == 127) chk("progempty_at_128", 72'(PROGEMPTY), 72'd1);
      if (i == 128) chk("progempty_at_129", 72'(PROGEMPTY), 72'd0);
      if (i == 254) chk("progfull_at_255", 72'(PROGFULL), 72'd0);
      if (i == 255) chk("progfull_at_256", 72'(PROGFULL), 72'd1);
      if (i == 510) chk("full_at_511", 72'(FULL), 72'd0);
    end
    chk("full_at_512", 72'(FULL), 72'd1);
    chk("wrcount_512", 72'(WRCOUNT), 72'd512);

    cycle(1'b1, 1'b0, 1'b0, 64'hDEAD_BEEF, 8'hEE);
    chk("overflow_wrerr", 72'(WRERR), 72'd1);
    chk("overflow_count", 72'(WRCOUNT), 72'd512);
    cycle(1'b0, 1'b0, 1'b0, 64'd0, 8'd0);
    chk("overflow_pulse_end", 72'(WRERR), 72'd0);

    for (int i = 0; i < 512; i++) begin
      chk("drain_dout", 72'(DOUT), 72'(BASE + 64'(i)));
      cycle(1'b0, 1'b1, 1'b0, 64'd0, 8'd0);
    end
    chk("drain_empty", 72'(EMPTY), 72'd1);

    // Full with simultaneous read: write rejected, read performed.
    for (int i = 0; i < 512; i++) cycle(1'b1, 1'b0, 1'b0, 64'(i) << 8, 8'(i + 3));
    cycle(1'b1, 1'b1, 1'b0, 64'hBAD, 8'h00);
    chk("full_rw_wrerr", 72'(WRERR), 72'd1);
    chk("full_rw_count", 72'(WRCOUNT), 72'd511);
    for (int i = 0; i < 511; i++) cycle(1'b0, 1'b1, 1'b0, 64'd0, 8'd0);

    // Steady-state simultaneous traffic at count 10.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 64'h1000 + 64'(i), 8'(i));
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 64'h2000 + 64'(i), 8'(i + 40));
      chk("simul_count", 72'(WRCOUNT), 72'd10);
    end
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 64'd0, 8'd0);

    // SLEEP blocks requests without error pulses.
    cycle(1'b1, 1'b1, 1'b1, 64'h5555, 8'h55);
    chk("sleep_empty_rderr", 72'(RDERR), 72'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 64'h3000 + 64'(i), 8'(i));
    cycle(1'b1, 1'b1, 1'b1, 64'h6666, 8'h66);
    chk("sleep_count", 72'(WRCOUNT), 72'd3);
    chk("sleep_dout", 72'(DOUT), 72'h3000);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 64'd0, 8'd0);

    // Reset in the middle of a fill.
    for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0, 1'b0, 64'h4000 + 64'(i), 8'(i));
    do_reset();
    chk("midrst_count", 72'(WRCOUNT), 72'd0);
    cycle(1'b1, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, 8'h5A);
    chk("midrst_first_dout", 72'(DOUT), 72'h0123_4567_89AB_CDEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo36e2.md
# fifo36e2

Single-clock 512 x 72 first-word-fall-through FIFO: 64 data bits plus 8 parity bits per word. It buffers streaming words between a producer and a consumer that share one clock. It provides occupancy counts, full/empty and programmable-threshold flags, overflow/underflow error pulses, and reset-busy indication.

## Interface
- PROG_EMPTY_THRESH, 13'd128: PROGEMPTY asserts while occupancy <= this value.
- PROG_FULL_THRESH, 13'd256: PROGFULL asserts while occupancy >= this value.
- SRVAL, 72'd0: value of {DOUTP, DOUT} during reset and while empty.
- WRCLK  in  1  the single clock; all reads and writes use its rising edge.
- RST  in  1  asynchronous, active-high reset.
- SLEEP  in  1  while 1, WREN and RDEN are ignored and all state holds.
- WREN  in  1  write request.
- DIN  in  64  write data.
- DINP  in  8  write parity.
- RDEN  in  1  read (pop) request.
- DOUT  out  64  head-of-FIFO data.
- DOUTP  out  8  head-of-FIFO parity.
- FULL, PROGFULL, EMPTY, PROGEMPTY  out  1 each  status flags.
- WRCOUNT, RDCOUNT  out  14 each  occupancy, 0..512; the two ports are identical.
- WRERR, RDERR  out  1 each  rejected-write / rejected-read pulse.
- WRRSTBUSY, RDRSTBUSY  out  1 each  reset in progress; the two ports are identical.

## Operation
- Storage: 512 words; wrapping 9-bit write and read pointers plus a 10-bit occupancy register.
- Accepted write: WREN=1, FULL=0, busy=0, SLEEP=0. Stores {DINP, DIN} at the write pointer, then increments the pointer.
- Accepted read: RDEN=1, EMPTY=0, busy=0, SLEEP=0. Increments the read pointer.
- Pointers wrap 511 -> 0.
- FWFT output: whenever EMPTY=0, {DOUTP, DOUT} = word at the read pointer; no RDEN is needed to present it. When EMPTY=1, DOUT/DOUTP = SRVAL.
- Flags are decoded from the occupancy register:
  - FULL = (count == 512).
  - EMPTY = (count == 0).
  - PROGFULL = (count >= PROG_FULL_THRESH).
  - PROGEMPTY = (count <= PROG_EMPTY_THRESH).
- Simultaneous accepted read and write: occupancy unchanged.
- Write while FULL is rejected, even if an accepted read occurs in the same cycle. The read is still performed.
- Read while EMPTY is rejected, even if a write occurs in the same cycle. The write is still performed.
- Rejected write: WRERR=1 for exactly the cycle after the rejected edge; memory, pointers and count are unchanged. Rejected read: RDERR=1 in the same way.
- Requests made while busy=1 or SLEEP=1 are ignored silently (no error pulse).
- Reset state machine, with states RESET -> BUSY -> IDLE:
  - RST=1 forces RESET immediately (asynchronous) from any state, including mid-transfer, and discards all contents.
  - On RST deassertion, BUSY lasts 4 WRCLK rising edges, then IDLE.
  - WRRSTBUSY = RDRSTBUSY = 1 in RESET and BUSY.

## Timing
- Reset values:
  - Pointers and count = 0.
  - EMPTY=1, PROGEMPTY=1, FULL=0, PROGFULL=0.
  - WRCOUNT = RDCOUNT = 0.
  - WRERR = RDERR = 0.
  - WRRSTBUSY = RDRSTBUSY = 1.
  - {DOUTP, DOUT} = SRVAL.
- Write latency: a write accepted at edge k updates count, flags and WRCOUNT/RDCOUNT right after edge k. If the FIFO was empty, EMPTY falls and DOUT shows the new word from edge k onward.
- Read: a pop at edge k presents the next word (or SRVAL if now empty) right after edge k.
- Full throughput: one write and one read per cycle; no bubbles.
- Error flags are registered, one-cycle pulses.

## Configuration
- FIFO36E2_PARITY_EN defined: memory is 72 bits wide; DINP is stored and DOUTP returns it.
- FIFO36E2_PARITY_EN undefined:
  - Memory is 64 bits wide and DINP is ignored.
  - DOUTP = SRVAL[71:64] at all times.
  - All flag, count and error behaviour is unchanged.

## Test plan
- Reset: hold RST=1 for 100 ns, release.
  - Required: busy=1 throughout and for exactly 4 edges after release; EMPTY=1, PROGEMPTY=1, counts 0, DOUT=0.
- Fill: write 512 words, DIN = 64'hFEDCBA98_76543210 + i, one per cycle, with RDEN=0.
  - EMPTY falls after the 1st write and DOUT = 64'hFEDCBA98_76543210.
  - PROGEMPTY falls at count 129; PROGFULL rises at count 256.
  - FULL rises at count 512; WRCOUNT = 512.
- Overflow: with the FIFO full, hold WREN=1 for 1 cycle.
  - WRERR pulses for one cycle; count stays 512.
  - Then drain 512 reads: DOUT sequence is +0 .. +511, EMPTY=1 at the end.
- Underflow and simultaneous access:
  - RDEN=1 while empty -> RDERR pulses once.
  - At count 10, WREN=RDEN=1 for 5 cycles -> count stays 10 and data order is preserved.
- Reset mid-operation: assert RST at count 300.
  - Required: flags and counts return to reset values immediately; after busy clears, the first new write appears on DOUT.
- SLEEP=1 with WREN=RDEN=1: no state change and no error pulses.
